temp_entry_sequencer: RTL and testbench
=======================================

Name: temp_entry_sequencer

Overview:
- Sequences operator keyboard entry for the monitoring datapath.
- Consumes filtered PS/2 make codes, one per `code_valid` tick, from the scan-code filter stage.
- Assembles a two-digit temperature setpoint, range-checks it on Enter, and issues a one-cycle load strobe with BCD digits to the temperature decoder.
- Also owns the Gas/Alerta/Peligro indicator flags and the FSM-reset request.

Parameters:
- MAX_TEMP, 50, largest setpoint accepted on Enter (0..99).
- TIMEOUT_CYC, 500000000, idle cycles tolerated mid-entry before abandoning it (32-bit counter).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; forces all registers to reset values.
- code_valid  input  1  one-cycle tick; `code` holds a filtered make code.
- code  input  8  PS/2 set-2 make code.
- temp_tens  output  4  committed tens digit (BCD).
- temp_units  output  4  committed units digit (BCD).
- temp_load  output  1  one-cycle pulse; new temp_tens/temp_units valid this cycle.
- gas  output  1  gas indicator flag.
- alerta  output  1  alert indicator flag.
- peligro  output  1  danger indicator flag.
- fsm_reset  output  1  one-cycle pulse requesting downstream FSM reset.
- entry_err  output  1  one-cycle pulse on rejected or timed-out entry.
- busy  output  1  high while state is GOT1 or GOT2.

Behaviour:
- Reset values:
  - state IDLE.
  - temp_tens = temp_units = 0.
  - gas = alerta = peligro = 0.
  - temp_load = fsm_reset = entry_err = busy = 0.
  - Digit buffers d1 = d2 = 0; timer 0.
- Key decode:
  - Digits: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
  - Enter 0x5A, Backspace 0x66, Esc 0x76.
  - G 0x34, A 0x1C, P 0x4D, R 0x2D.
  - Any other code is ignored, with no state or timer change.
- Latency and outputs:
  - All outputs are registered.
  - The response to a code sampled at edge k is visible after edge k: 1-cycle latency.
  - Pulses are high for exactly one cycle.
- States:
  - IDLE:
    - digit → d1 = digit, go GOT1.
    - Enter, Backspace, Esc → ignored.
  - GOT1:
    - digit → d2 = digit, go GOT2.
    - Enter → commit value d1 (tens 0, units d1).
    - Backspace or Esc → IDLE.
  - GOT2:
    - Enter → commit value 10*d1 + d2.
    - Backspace → GOT1, d1 kept.
    - Esc → IDLE.
    - Further digits → ignored, no error.
- Commit:
  - If value ≤ MAX_TEMP: temp_tens/temp_units load the BCD digits and temp_load pulses.
  - Otherwise: outputs are unchanged and entry_err pulses.
  - Either way the next state is IDLE.
- Flag keys (G, A, P):
  - In any state, toggle gas, alerta or peligro respectively.
  - Entry state, digit buffers and timer are untouched.
- R key:
  - In any state: fsm_reset pulses, all three flags clear to 0, state goes to IDLE, pending digits are discarded.
  - temp_tens/temp_units are retained.
- Timer:
  - Counts only in GOT1/GOT2.
  - Clears on entering IDLE and on every accepted digit, Enter or Backspace.
  - On reaching TIMEOUT_CYC-1 with no code this cycle: state goes to IDLE and entry_err pulses.
- Simultaneous events: a code_valid in the timeout cycle takes priority and the timeout does not fire.
- code_valid on consecutive cycles: each code is processed in order; there is no backpressure.
- Asynchronous reset mid-entry: discards digits, clears flags and committed temperature immediately, with no pulses.

Test Plan:
- Reset, then codes 0x1E, 0x25, 0x5A → temp_load single pulse; temp_tens=2, temp_units=4; busy high from the cycle after 0x1E until the cycle after 0x5A.
- MAX_TEMP=50; codes 0x2E, 0x16, 0x5A (51) → entry_err pulse, no temp_load, temp stays 2/4. Then 0x2E, 0x45, 0x5A (50) → temp 5/0 loaded.
- Codes 0x3D, 0x5A → temp 0/7. Then 0x26, 0x36, 0x66, 0x46, 0x5A → temp 3/9 (backspace replaces units). Then 0x16, 0x76, 0x5A → no load.
- Codes 0x34, 0x4D, then 0x16 followed by 0x1C mid-entry → gas=1, peligro=1, alerta=1 with entry still GOT1. Then 0x2D → fsm_reset pulse, all flags 0, busy 0, temp unchanged.
- TIMEOUT_CYC=20; code 0x16 then idle → entry_err pulses exactly 20 cycles after the digit's cycle, busy drops. A variant with 0x16 arriving in the timeout cycle → no error, GOT2 reached.
- Assert reset asynchronously between two digits → all outputs return to reset values before the next edge; a following 0x5A produces no load.

Source files
------------

// File: rtl/temp_entry_sequencer.sv
// temp_entry_sequencer: turns filtered PS/2 make codes into a two-digit
// temperature setpoint (BCD), keeps the Gas/Alerta/Peligro indicator flags,
// and raises the downstream FSM-reset request. All outputs are registered,
// so every response appears one clock after the code is sampled.
module temp_entry_sequencer #(
    parameter int unsigned MAX_TEMP    = 50,
    parameter int unsigned TIMEOUT_CYC = 500000000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic [3:0] temp_tens,
    output logic [3:0] temp_units,
    output logic       temp_load,
    output logic       gas,
    output logic       alerta,
    output logic       peligro,
    output logic       fsm_reset,
    output logic       entry_err,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GOT1 = 2'd1;
    localparam logic [1:0] S_GOT2 = 2'd2;

    // Last timer value before an abandoned entry is dropped.
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] MAX_VAL    = 32'(MAX_TEMP);

    logic [1:0]  r_state;
    logic [3:0]  r_d1;
    logic [3:0]  r_d2;
    logic [31:0] r_timer;
    logic [3:0]  r_tens;
    logic [3:0]  r_units;
    logic        r_load;
    logic        r_gas;
    logic        r_alerta;
    logic        r_peligro;
    logic        r_fsm_rst;
    logic        r_err;
    logic        r_busy;

    logic        w_is_digit;
    logic [3:0]  w_digit;
    logic        w_enter;
    logic        w_bksp;
    logic        w_esc;
    logic        w_key_g;
    logic        w_key_a;
    logic        w_key_p;
    logic        w_key_r;

    logic [1:0]  w_state_n;
    logic [3:0]  w_d1_n;
    logic [3:0]  w_d2_n;
    logic [31:0] w_timer_n;
    logic [3:0]  w_tens_n;
    logic [3:0]  w_units_n;
    logic        w_load_n;
    logic        w_gas_n;
    logic        w_alerta_n;
    logic        w_peligro_n;
    logic        w_fsm_rst_n;
    logic        w_err_n;

    logic [6:0]  w_val;
    logic        w_val_ok;
    logic [3:0]  w_commit_tens;
    logic [3:0]  w_commit_units;

    // Decode the sampled make code into digit / command strobes (qualified by code_valid).
    always_comb begin
        w_is_digit = 1'b0;
        w_digit    = 4'd0;
        w_enter    = 1'b0;
        w_bksp     = 1'b0;
        w_esc      = 1'b0;
        w_key_g    = 1'b0;
        w_key_a    = 1'b0;
        w_key_p    = 1'b0;
        w_key_r    = 1'b0;
        if (code_valid) begin
            case (code)
                8'h45: begin w_is_digit = 1'b1; w_digit = 4'd0; end
                8'h16: begin w_is_digit = 1'b1; w_digit = 4'd1; end
                8'h1E: begin w_is_digit = 1'b1; w_digit = 4'd2; end
                8'h26: begin w_is_digit = 1'b1; w_digit = 4'd3; end
                8'h25: begin w_is_digit = 1'b1; w_digit = 4'd4; end
                8'h2E: begin w_is_digit = 1'b1; w_digit = 4'd5; end
                8'h36: begin w_is_digit = 1'b1; w_digit = 4'd6; end
                8'h3D: begin w_is_digit = 1'b1; w_digit = 4'd7; end
                8'h3E: begin w_is_digit = 1'b1; w_digit = 4'd8; end
                8'h46: begin w_is_digit = 1'b1; w_digit = 4'd9; end
                8'h5A: w_enter = 1'b1;
                8'h66: w_bksp  = 1'b1;
                8'h76: w_esc   = 1'b1;
                8'h34: w_key_g = 1'b1;
                8'h1C: w_key_a = 1'b1;
                8'h4D: w_key_p = 1'b1;
                8'h2D: w_key_r = 1'b1;
                default: ;
            endcase
        end
    end

    // Candidate setpoint for Enter: a single digit commits as 0d, two digits as d1d2.
    always_comb begin
        if (r_state == S_GOT2) begin
            w_val          = 7'(r_d1) * 7'd10 + 7'(r_d2);
            w_commit_tens  = r_d1;
            w_commit_units = r_d2;
        end else begin
            w_val          = 7'(r_d1);
            w_commit_tens  = 4'd0;
            w_commit_units = r_d1;
        end
        w_val_ok = ({25'd0, w_val} <= MAX_VAL);
    end

    // Next-state logic: R beats flag keys, flag keys leave entry untouched, then entry FSM.
    always_comb begin
        w_state_n   = r_state;
        w_d1_n      = r_d1;
        w_d2_n      = r_d2;
        w_timer_n   = r_timer;
        w_tens_n    = r_tens;
        w_units_n   = r_units;
        w_load_n    = 1'b0;
        w_gas_n     = r_gas;
        w_alerta_n  = r_alerta;
        w_peligro_n = r_peligro;
        w_fsm_rst_n = 1'b0;
        w_err_n     = 1'b0;

        if (w_key_r) begin
            w_fsm_rst_n = 1'b1;
            w_gas_n     = 1'b0;
            w_alerta_n  = 1'b0;
            w_peligro_n = 1'b0;
            w_state_n   = S_IDLE;
            w_d1_n      = 4'd0;
            w_d2_n      = 4'd0;
            w_timer_n   = 32'd0;
        end else if (w_key_g) begin
            w_gas_n = ~r_gas;
        end else if (w_key_a) begin
            w_alerta_n = ~r_alerta;
        end else if (w_key_p) begin
            w_peligro_n = ~r_peligro;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_digit) begin
                        w_d1_n    = w_digit;
                        w_state_n = S_GOT1;
                        w_timer_n = 32'd0;
                    end
                end
                S_GOT1, S_GOT2: begin
                    if (w_enter) begin
                        w_state_n = S_IDLE;
                        w_timer_n = 32'd0;
                        if (w_val_ok) begin
                            w_tens_n  = w_commit_tens;
                            w_units_n = w_commit_units;
                            w_load_n  = 1'b1;
                        end else begin
                            w_err_n = 1'b1;
                        end
                    end else if (w_is_digit && r_state == S_GOT1) begin
                        w_d2_n    = w_digit;
                        w_state_n = S_GOT2;
                        w_timer_n = 32'd0;
                    end else if (w_bksp) begin
                        w_state_n = (r_state == S_GOT2) ? S_GOT1 : S_IDLE;
                        w_timer_n = 32'd0;
                    end else if (w_esc) begin
                        w_state_n = S_IDLE;
                        w_timer_n = 32'd0;
                    end else if (!code_valid) begin
                        // Only truly idle cycles age the entry; ignored codes freeze the timer.
                        if (r_timer == TIMER_LAST) begin
                            w_state_n = S_IDLE;
                            w_timer_n = 32'd0;
                            w_err_n   = 1'b1;
                        end else begin
                            w_timer_n = r_timer + 32'd1;
                        end
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_timer_n = 32'd0;
                end
            endcase
        end
    end

    // State and output registers; asynchronous reset returns everything to idle/zero.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_d1      <= 4'd0;
            r_d2      <= 4'd0;
            r_timer   <= 32'd0;
            r_tens    <= 4'd0;
            r_units   <= 4'd0;
            r_load    <= 1'b0;
            r_gas     <= 1'b0;
            r_alerta  <= 1'b0;
            r_peligro <= 1'b0;
            r_fsm_rst <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_d1      <= w_d1_n;
            r_d2      <= w_d2_n;
            r_timer   <= w_timer_n;
            r_tens    <= w_tens_n;
            r_units   <= w_units_n;
            r_load    <= w_load_n;
            r_gas     <= w_gas_n;
            r_alerta  <= w_alerta_n;
            r_peligro <= w_peligro_n;
            r_fsm_rst <= w_fsm_rst_n;
            r_err     <= w_err_n;
            r_busy    <= (w_state_n != S_IDLE);
        end
    end

    assign temp_tens  = r_tens;
    assign temp_units = r_units;
    assign temp_load  = r_load;
    assign gas        = r_gas;
    assign alerta     = r_alerta;
    assign peligro    = r_peligro;
    assign fsm_reset  = r_fsm_rst;
    assign entry_err  = r_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_temp_entry_sequencer.sv
// Directed bench for temp_entry_sequencer (MAX_TEMP=50, TIMEOUT_CYC=20).
module tb_temp_entry_sequencer;

    logic       CLK = 1'b0;
    logic       reset;
    logic       code_valid;
    logic [7:0] code;
    logic [3:0] temp_tens;
    logic [3:0] temp_units;
    logic       temp_load;
    logic       gas;
    logic       alerta;
    logic       peligro;
    logic       fsm_reset;
    logic       entry_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    temp_entry_sequencer #(
        .MAX_TEMP    (50),
        .TIMEOUT_CYC (20)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .code_valid (code_valid),
        .code       (code),
        .temp_tens  (temp_tens),
        .temp_units (temp_units),
        .temp_load  (temp_load),
        .gas        (gas),
        .alerta     (alerta),
        .peligro    (peligro),
        .fsm_reset  (fsm_reset),
        .entry_err  (entry_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        code       = c;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        code       = 8'h00;
    endtask

    logic [11:0] all_out;
    assign all_out = {temp_tens, temp_units, temp_load, gas, alerta, peligro,
                      fsm_reset, entry_err, busy};

    logic seen_err;

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        code       = 8'h00;
        tick();
        tick();
        chk("reset_held_outputs", 32'(all_out), 32'd0);
        reset = 1'b0;
        tick();
        chk("after_reset_outputs", 32'(all_out), 32'd0);

        // Basic entry 24
        send(8'h1E);
        chk("t1_busy_after_first", 32'(busy), 32'd1);
        chk("t1_no_load_yet", 32'(temp_load), 32'd0);
        send(8'h25);
        chk("t1_busy_got2", 32'(busy), 32'd1);
        send(8'h5A);
        chk("t1_load_pulse", 32'(temp_load), 32'd1);
        chk("t1_temp", 32'({temp_tens, temp_units}), 32'h24);
        chk("t1_busy_drop", 32'(busy), 32'd0);
        tick();
        chk("t1_load_one_cycle", 32'(temp_load), 32'd0);

        // 51 rejected, 50 accepted
        send(8'h2E);
        send(8'h16);
        send(8'h5A);
        chk("t2_err_pulse", 32'(entry_err), 32'd1);
        chk("t2_no_load", 32'(temp_load), 32'd0);
        chk("t2_temp_kept", 32'({temp_tens, temp_units}), 32'h24);
        tick();
        chk("t2_err_one_cycle", 32'(entry_err), 32'd0);
        send(8'h2E);
        send(8'h45);
        send(8'h5A);
        chk("t2_load_50", 32'(temp_load), 32'd1);
        chk("t2_temp_50", 32'({temp_tens, temp_units}), 32'h50);
        chk("t2_no_err_50", 32'(entry_err), 32'd0);

        // Single digit, backspace, escape
        send(8'h3D);
        send(8'h5A);
        chk("t3_load_07", 32'(temp_load), 32'd1);
        chk("t3_temp_07", 32'({temp_tens, temp_units}), 32'h07);
        send(8'h26);
        send(8'h36);
        send(8'h66);
        chk("t3_bksp_busy", 32'(busy), 32'd1);
        send(8'h46);
        send(8'h5A);
        chk("t3_load_39", 32'(temp_load), 32'd1);
        chk("t3_temp_39", 32'({temp_tens, temp_units}), 32'h39);
        send(8'h16);
        send(8'h76);
        chk("t3_esc_idle", 32'(busy), 32'd0);
        send(8'h5A);
        chk("t3_enter_idle_no_load", 32'(temp_load), 32'd0);
        chk("t3_enter_idle_no_err", 32'(entry_err), 32'd0);
        chk("t3_temp_still_39", 32'({temp_tens, temp_units}), 32'h39);

        // Flags and R key
        send(8'h34);
        chk("t4_gas_on", 32'(gas), 32'd1);
        send(8'h4D);
        chk("t4_peligro_on", 32'(peligro), 32'd1);
        send(8'h16);
        send(8'h1C);
        chk("t4_flags_mid_entry", 32'({gas, alerta, peligro, busy}), 32'b1111);
        send(8'h2D);
        chk("t4_fsm_reset_pulse", 32'(fsm_reset), 32'd1);
        chk("t4_flags_cleared", 32'({gas, alerta, peligro, busy}), 32'b0000);
        chk("t4_temp_retained", 32'({temp_tens, temp_units}), 32'h39);
        tick();
        chk("t4_fsm_reset_one_cycle", 32'(fsm_reset), 32'd0);
        send(8'h5A);
        chk("t4_digits_discarded", 32'(temp_load), 32'd0);

        // Unknown code ignored mid-entry
        send(8'h16);
        send(8'hFF);
        chk("t5_unknown_busy", 32'(busy), 32'd1);
        send(8'h36);
        send(8'h5A);
        chk("t5_load_16", 32'(temp_load), 32'd1);
        chk("t5_temp_16", 32'({temp_tens, temp_units}), 32'h16);

        // Timeout exactly 20 cycles after the digit
        send(8'h16);
        seen_err = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (entry_err) seen_err = 1'b1;
        end
        chk("t6_no_early_timeout", 32'(seen_err), 32'd0);
        chk("t6_busy_before_timeout", 32'(busy), 32'd1);
        tick();
        chk("t6_timeout_err", 32'(entry_err), 32'd1);
        chk("t6_timeout_idle", 32'(busy), 32'd0);
        tick();
        chk("t6_err_one_cycle", 32'(entry_err), 32'd0);

        // Digit arriving in the timeout cycle wins
        send(8'h16);
        for (int i = 0; i < 19; i++) tick();
        send(8'h26);
        chk("t7_no_timeout_err", 32'(entry_err), 32'd0);
        chk("t7_still_busy", 32'(busy), 32'd1);
        send(8'h5A);
        chk("t7_got2_commit", 32'(temp_load), 32'd1);
        chk("t7_temp_13", 32'({temp_tens, temp_units}), 32'h13);

        // Asynchronous reset between digits
        send(8'h34);
        send(8'h16);
        chk("t8_pre_reset_state", 32'({gas, busy}), 32'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("t8_async_reset_outputs", 32'(all_out), 32'd0);
        #1;
        reset = 1'b0;
        send(8'h5A);
        chk("t8_no_load_after_reset", 32'(temp_load), 32'd0);
        chk("t8_outputs_after_enter", 32'(all_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
